// File: rtl/tt_serial_tx.sv
// tt_serial_tx: byte-oriented asynchronous serial transmitter (8N1 / 8E1 / 8N2).
// Accepts a byte on a valid/ready handshake and emits start, 8 data bits
// LSB first, an optional even-parity bit and one or two stop bits on tx_out.
// tx_out and busy are registered; tx_ready is a function of state and rst only.
module tt_serial_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                parity_q, parity_d;
  logic                tx_out_q, tx_out_d;
  logic                busy_q, busy_d;
  logic                handshake;
  logic                baud_tc;

  assign tx_ready  = (state_q == S_IDLE) & ~rst;
  assign handshake = tx_valid & tx_ready;
  assign baud_tc   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign tx_out    = tx_out_q;
  assign busy      = busy_q;

  // Next-state, counter and shift-register logic; outputs are derived from the
  // next state so the registered line changes on the same edge as the state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    baud_d   = baud_q + BAUD_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (handshake) begin
          state_d  = S_START;
          shift_d  = tx_data;
          parity_d = ^tx_data;
          bit_d    = '0;
        end
      end
      S_START: begin
        if (baud_tc) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (baud_tc) begin
          state_d = S_STOP;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == 3'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    case (state_d)
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = shift_d[0];
      S_PARITY: tx_out_d = parity_d;
      default:  tx_out_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, counters, data and registered outputs; rst overrides everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_tt_serial_tx.sv
// tb_tt_serial_tx: three transmitter instances (8N1, 8E1, 8N2 at 4 clocks/bit)
// driven by directed and random frames; every line cycle is compared against a
// frame model, and each captured frame is decoded by a mid-bit sampling receiver.
module tb_tt_serial_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data_r  [3];
  logic       tx_valid_r [3];
  logic       tx_ready_w [3];
  logic       tx_out_w   [3];
  logic       busy_w     [3];

  int checks = 0;
  int errors = 0;
  bit trace [0:255];

  always #5 clk = ~clk;

  tt_serial_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_8n1 (
    .clk(clk), .rst(rst), .tx_data(tx_data_r[0]), .tx_valid(tx_valid_r[0]),
    .tx_ready(tx_ready_w[0]), .tx_out(tx_out_w[0]), .busy(busy_w[0]));

  tt_serial_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut_8e1 (
    .clk(clk), .rst(rst), .tx_data(tx_data_r[1]), .tx_valid(tx_valid_r[1]),
    .tx_ready(tx_ready_w[1]), .tx_out(tx_out_w[1]), .busy(busy_w[1]));

  tt_serial_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) dut_8n2 (
    .clk(clk), .rst(rst), .tx_data(tx_data_r[2]), .tx_valid(tx_valid_r[2]),
    .tx_ready(tx_ready_w[2]), .tx_out(tx_out_w[2]), .busy(busy_w[2]));

  // Frame format of each instance.
  function automatic int par_en(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic int stop_bits(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int k);
    return (1 + 8 + par_en(k) + stop_bits(k)) * CPB;
  endfunction

  // Even parity: the parity bit is 1 when the byte holds an odd number of ones.
  function automatic bit par_bit(input logic [7:0] b);
    int ones = 0;
    int v = int'(b);
    for (int i = 0; i < 8; i++) ones += (v >> i) & 1;
    return (ones % 2) == 1;
  endfunction

  // Expected line level during cycle i of a frame carrying byte b.
  function automatic bit exp_bit(input int k, input logic [7:0] b, input int i);
    int n = i / CPB;
    int v = int'(b);
    if (n == 0) return 1'b0;
    if (n <= 8) return ((v >> (n - 1)) & 1) == 1;
    if (par_en(k) == 1 && n == 9) return par_bit(b);
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Board-side receiver: samples the captured line in the middle of each bit.
  task automatic decode_check(input int k, input logic [7:0] b);
    logic [7:0] d = '0;
    bit framing_ok = 1'b1;
    int half = CPB / 2;
    if (trace[half] != 1'b0) framing_ok = 1'b0;
    for (int j = 0; j < 8; j++) d[j] = trace[(1 + j) * CPB + half];
    if (par_en(k) == 1 && trace[9 * CPB + half] != par_bit(d)) framing_ok = 1'b0;
    for (int s = 0; s < stop_bits(k); s++)
      if (trace[(9 + par_en(k) + s) * CPB + half] != 1'b1) framing_ok = 1'b0;
    check($sformatf("rx%0d_decode", k), {23'd0, framing_ok, d}, {23'd0, 1'b1, b});
  endtask

  // Sends one byte on instance k and checks every cycle of the frame.
  // hold keeps tx_valid high after the handshake, toggle scrambles tx_data
  // while busy, abort_at >= 0 pulses rst at that frame cycle.
  task automatic send_frame(input int k, input logic [7:0] b, input bit hold,
                            input bit toggle, input int abort_at);
    int waited = 0;
    int f = frame_len(k);
    bit quiet;
    while (tx_ready_w[k] !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("tx%0d_ready_wait", k), {31'd0, tx_ready_w[k]}, 32'd1);
    tx_data_r[k]  = b;
    tx_valid_r[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) tx_valid_r[k] = 1'b0;
    for (int i = 0; i < f; i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check($sformatf("tx%0d_abort_rst", k),
              {29'd0, busy_w[k], tx_out_w[k], tx_ready_w[k]}, {29'd0, 3'b010});
        rst = 1'b0;
        #1;
        check($sformatf("tx%0d_abort_ready", k), {31'd0, tx_ready_w[k]}, 32'd1);
        quiet = 1'b1;
        for (int c = 0; c < 3 * CPB; c++) begin
          @(negedge clk);
          if (tx_out_w[k] !== 1'b1 || busy_w[k] !== 1'b0) quiet = 1'b0;
        end
        check($sformatf("tx%0d_abort_quiet", k), {31'd0, quiet}, 32'd1);
        return;
      end
      trace[i] = tx_out_w[k];
      check($sformatf("tx%0d_cyc%0d", k, i),
            {29'd0, busy_w[k], tx_out_w[k], tx_ready_w[k]},
            {29'd0, 1'b1, exp_bit(k, b, i), 1'b0});
      if (toggle) tx_data_r[k] = 8'($urandom);
      @(negedge clk);
    end
    check($sformatf("tx%0d_idle", k),
          {29'd0, busy_w[k], tx_out_w[k], tx_ready_w[k]}, {29'd0, 3'b011});
    decode_check(k, b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tx_data_r[k]  = 8'hFF;
      tx_valid_r[k] = 1'b1;
    end

    // Reset held with a pending byte: line idle, no ready, no start bit.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        check($sformatf("rst%0d_cyc%0d", k, c),
              {29'd0, busy_w[k], tx_out_w[k], tx_ready_w[k]}, {29'd0, 3'b010});
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) tx_valid_r[k] = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("rst%0d_release_ready", k), {31'd0, tx_ready_w[k]}, 32'd1);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("rst%0d_no_start", k),
            {29'd0, busy_w[k], tx_out_w[k], tx_ready_w[k]}, {29'd0, 3'b011});

    // 8N1 frame of 0xA5: 40 busy cycles, ready again on cycle 41.
    send_frame(0, 8'hA5, 1'b0, 1'b0, -1);

    // Even parity: 0x07 gives parity 1, 0x03 gives parity 0.
    send_frame(1, 8'h07, 1'b0, 1'b0, -1);
    send_frame(1, 8'h03, 1'b0, 1'b0, -1);

    // tx_valid held high: back-to-back frames with one idle cycle between.
    send_frame(0, 8'h55, 1'b1, 1'b0, -1);
    send_frame(0, 8'hAA, 1'b0, 1'b0, -1);

    // Reset during data bit 3 of 0xC3, then a clean 0x3C.
    send_frame(0, 8'hC3, 1'b0, 1'b0, (1 + 3) * CPB + 1);
    send_frame(0, 8'h3C, 1'b0, 1'b0, -1);

    // Two stop bits with tx_data scrambled during the frame.
    send_frame(2, 8'h96, 1'b0, 1'b1, -1);

    // Random bytes on every format, mixing held valid and data scrambling.
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 4; j++)
        send_frame(k, 8'($urandom), (j < 3), 1'($urandom_range(0, 1)), -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
